// File: rtl/cam_alloc_controller.sv
// Requesting side of the dispatcher resource CAM: keeps the per-CU free-slot table,
// issues CAM searches for allocations and CAM writes for every table update.
module cam_alloc_controller #(
  parameter int CU_ID_WIDTH      = 6,
  parameter int NUMBER_CU        = 64,
  parameter int RES_ID_WIDTH     = 10,
  parameter int NUMBER_RES_SLOTS = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    alloc_valid_i,
  input  logic [RES_ID_WIDTH:0]   alloc_size_i,
  output logic                    alloc_ready_o,
  output logic                    alloc_done_o,
  output logic                    alloc_success_o,
  output logic [CU_ID_WIDTH-1:0]  alloc_cu_id_o,
  input  logic                    dealloc_valid_i,
  input  logic [CU_ID_WIDTH-1:0]  dealloc_cu_id_i,
  input  logic [RES_ID_WIDTH:0]   dealloc_size_i,
  output logic                    dealloc_ready_o,
  output logic                    dealloc_overflow_o,
  output logic                    res_search_en_o,
  output logic [RES_ID_WIDTH:0]   res_search_size_o,
  input  logic [NUMBER_CU-1:0]    res_search_out_i,
  output logic                    cam_wr_en_o,
  output logic [CU_ID_WIDTH-1:0]  cam_wr_addr_o,
  output logic [RES_ID_WIDTH:0]   cam_wr_data_o
);

  localparam logic [RES_ID_WIDTH:0] MAX_SLOTS = (RES_ID_WIDTH+1)'(NUMBER_RES_SLOTS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEARCH,
    ST_EVAL,
    ST_DEALLOC
  } state_t;

  state_t                  state_q, state_d;
  logic [RES_ID_WIDTH:0]   size_q, size_d;
  logic [CU_ID_WIDTH-1:0]  cu_q, cu_d;
  logic                    search_en_q, search_en_d;
  logic [RES_ID_WIDTH:0]   search_size_q, search_size_d;
  logic                    done_q, done_d;
  logic                    success_q, success_d;
  logic [CU_ID_WIDTH-1:0]  cu_id_q, cu_id_d;
  logic                    wr_en_q, wr_en_d;
  logic [CU_ID_WIDTH-1:0]  wr_addr_q, wr_addr_d;
  logic [RES_ID_WIDTH:0]   wr_data_q, wr_data_d;
  logic                    ovf_q, ovf_d;

  logic [RES_ID_WIDTH:0]   tbl_q [NUMBER_CU];
  logic                    tbl_we;
  logic [CU_ID_WIDTH-1:0]  tbl_waddr;
  logic [RES_ID_WIDTH:0]   tbl_wdata;

  logic                    hit;
  logic [CU_ID_WIDTH-1:0]  hit_idx;
  logic [RES_ID_WIDTH+1:0] dealloc_sum;
  logic                    dealloc_clamp;

  // Lowest-index hitting CU wins: scan downward so the last assignment is the lowest bit.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUMBER_CU - 1; i >= 0; i--) begin
      if (res_search_out_i[i]) begin
        hit     = 1'b1;
        hit_idx = CU_ID_WIDTH'(i);
      end
    end
  end

  assign dealloc_sum   = {1'b0, tbl_q[cu_q]} + {1'b0, size_q};
  assign dealloc_clamp = dealloc_sum > {1'b0, MAX_SLOTS};

  always_comb begin
    state_d       = state_q;
    size_d        = size_q;
    cu_d          = cu_q;
    search_en_d   = 1'b0;
    search_size_d = '0;
    done_d        = 1'b0;
    success_d     = 1'b0;
    cu_id_d       = '0;
    wr_en_d       = 1'b0;
    wr_addr_d     = '0;
    wr_data_d     = '0;
    ovf_d         = 1'b0;
    tbl_we        = 1'b0;
    tbl_waddr     = '0;
    tbl_wdata     = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (dealloc_valid_i) begin
          state_d = ST_DEALLOC;
          cu_d    = dealloc_cu_id_i;
          size_d  = dealloc_size_i;
        end else if (alloc_valid_i) begin
          state_d = ST_SEARCH;
          size_d  = alloc_size_i;
          // Oversized requests never reach the CAM; EVAL reports them as a miss.
          if (alloc_size_i <= MAX_SLOTS) begin
            search_en_d   = 1'b1;
            search_size_d = alloc_size_i;
          end
        end
      end
      ST_SEARCH: state_d = ST_EVAL;
      ST_EVAL: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        if (hit && (size_q <= MAX_SLOTS)) begin
          success_d = 1'b1;
          cu_id_d   = hit_idx;
          wr_en_d   = 1'b1;
          wr_addr_d = hit_idx;
          wr_data_d = tbl_q[hit_idx] - size_q;
          tbl_we    = 1'b1;
          tbl_waddr = hit_idx;
          tbl_wdata = tbl_q[hit_idx] - size_q;
        end
      end
      ST_DEALLOC: begin
        state_d   = ST_IDLE;
        wr_en_d   = 1'b1;
        wr_addr_d = cu_q;
        wr_data_d = dealloc_clamp ? MAX_SLOTS : dealloc_sum[RES_ID_WIDTH:0];
        ovf_d     = dealloc_clamp;
        tbl_we    = 1'b1;
        tbl_waddr = cu_q;
        tbl_wdata = dealloc_clamp ? MAX_SLOTS : dealloc_sum[RES_ID_WIDTH:0];
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      size_q        <= '0;
      cu_q          <= '0;
      search_en_q   <= 1'b0;
      search_size_q <= '0;
      done_q        <= 1'b0;
      success_q     <= 1'b0;
      cu_id_q       <= '0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      ovf_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      size_q        <= size_d;
      cu_q          <= cu_d;
      search_en_q   <= search_en_d;
      search_size_q <= search_size_d;
      done_q        <= done_d;
      success_q     <= success_d;
      cu_id_q       <= cu_id_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      ovf_q         <= ovf_d;
    end
  end

  // Reset value mirrors the CAM's invalid state, which matches every search size.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUMBER_CU; i++) tbl_q[i] <= MAX_SLOTS;
    end else if (tbl_we) begin
      tbl_q[tbl_waddr] <= tbl_wdata;
    end
  end

  assign alloc_ready_o      = (state_q == ST_IDLE) && !dealloc_valid_i;
  assign dealloc_ready_o    = (state_q == ST_IDLE);
  assign alloc_done_o       = done_q;
  assign alloc_success_o    = success_q;
  assign alloc_cu_id_o      = cu_id_q;
  assign dealloc_overflow_o = ovf_q;
  assign res_search_en_o    = search_en_q;
  assign res_search_size_o  = search_size_q;
  assign cam_wr_en_o        = wr_en_q;
  assign cam_wr_addr_o      = wr_addr_q;
  assign cam_wr_data_o      = wr_data_q;

endmodule

// File: tb/tb_cam_alloc_controller.sv
// Directed bench for cam_alloc_controller: hand-computed cycle-by-cycle expectations.
module tb_cam_alloc_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        alloc_valid;
  logic [10:0] alloc_size;
  logic        alloc_ready;
  logic        alloc_done;
  logic        alloc_success;
  logic [5:0]  alloc_cu_id;
  logic        dealloc_valid;
  logic [5:0]  dealloc_cu_id;
  logic [10:0] dealloc_size;
  logic        dealloc_ready;
  logic        dealloc_overflow;
  logic        res_search_en;
  logic [10:0] res_search_size;
  logic [63:0] res_search_out;
  logic        cam_wr_en;
  logic [5:0]  cam_wr_addr;
  logic [10:0] cam_wr_data;

  int checks = 0;
  int errors = 0;

  cam_alloc_controller dut (
    .clk                (clk),
    .rst                (rst),
    .alloc_valid_i      (alloc_valid),
    .alloc_size_i       (alloc_size),
    .alloc_ready_o      (alloc_ready),
    .alloc_done_o       (alloc_done),
    .alloc_success_o    (alloc_success),
    .alloc_cu_id_o      (alloc_cu_id),
    .dealloc_valid_i    (dealloc_valid),
    .dealloc_cu_id_i    (dealloc_cu_id),
    .dealloc_size_i     (dealloc_size),
    .dealloc_ready_o    (dealloc_ready),
    .dealloc_overflow_o (dealloc_overflow),
    .res_search_en_o    (res_search_en),
    .res_search_size_o  (res_search_size),
    .res_search_out_i   (res_search_out),
    .cam_wr_en_o        (cam_wr_en),
    .cam_wr_addr_o      (cam_wr_addr),
    .cam_wr_data_o      (cam_wr_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1 of cycle N with the FSM idle.
  task automatic do_alloc(input string tag, input logic [10:0] size, input logic [63:0] bm,
                          input logic exp_en, input logic exp_succ,
                          input logic [5:0] exp_cu, input logic [10:0] exp_data);
    res_search_out = bm;
    alloc_size     = size;
    alloc_valid    = 1'b1;
    #1;
    chk({tag, " ready"}, 32'(alloc_ready), 32'd1);
    step();
    alloc_valid = 1'b0;
    chk({tag, " n1 search_en"}, 32'(res_search_en), 32'(exp_en));
    chk({tag, " n1 search_size"}, 32'(res_search_size), exp_en ? 32'(size) : 32'd0);
    chk({tag, " n1 done"}, 32'(alloc_done), 32'd0);
    chk({tag, " n1 wr_en"}, 32'(cam_wr_en), 32'd0);
    step();
    chk({tag, " n2 search_en"}, 32'(res_search_en), 32'd0);
    chk({tag, " n2 done"}, 32'(alloc_done), 32'd0);
    chk({tag, " n2 wr_en"}, 32'(cam_wr_en), 32'd0);
    step();
    chk({tag, " n3 done"}, 32'(alloc_done), 32'd1);
    chk({tag, " n3 success"}, 32'(alloc_success), 32'(exp_succ));
    chk({tag, " n3 cu_id"}, 32'(alloc_cu_id), 32'(exp_cu));
    chk({tag, " n3 wr_en"}, 32'(cam_wr_en), 32'(exp_succ));
    if (exp_succ) begin
      chk({tag, " n3 wr_addr"}, 32'(cam_wr_addr), 32'(exp_cu));
      chk({tag, " n3 wr_data"}, 32'(cam_wr_data), 32'(exp_data));
    end
    step();
    chk({tag, " n4 done"}, 32'(alloc_done), 32'd0);
    chk({tag, " n4 wr_en"}, 32'(cam_wr_en), 32'd0);
  endtask

  task automatic do_dealloc(input string tag, input logic [5:0] cu, input logic [10:0] size,
                            input logic [10:0] exp_data, input logic exp_ovf);
    dealloc_cu_id = cu;
    dealloc_size  = size;
    dealloc_valid = 1'b1;
    #1;
    chk({tag, " dready"}, 32'(dealloc_ready), 32'd1);
    chk({tag, " aready"}, 32'(alloc_ready), 32'd0);
    step();
    dealloc_valid = 1'b0;
    chk({tag, " n1 wr_en"}, 32'(cam_wr_en), 32'd0);
    chk({tag, " n1 dready"}, 32'(dealloc_ready), 32'd0);
    step();
    chk({tag, " n2 wr_en"}, 32'(cam_wr_en), 32'd1);
    chk({tag, " n2 wr_addr"}, 32'(cam_wr_addr), 32'(cu));
    chk({tag, " n2 wr_data"}, 32'(cam_wr_data), 32'(exp_data));
    chk({tag, " n2 ovf"}, 32'(dealloc_overflow), 32'(exp_ovf));
    chk({tag, " n2 dready"}, 32'(dealloc_ready), 32'd1);
    step();
    chk({tag, " n3 wr_en"}, 32'(cam_wr_en), 32'd0);
    chk({tag, " n3 ovf"}, 32'(dealloc_overflow), 32'd0);
  endtask

  initial begin
    rst            = 1'b1;
    alloc_valid    = 1'b0;
    alloc_size     = '0;
    dealloc_valid  = 1'b0;
    dealloc_cu_id  = '0;
    dealloc_size   = '0;
    res_search_out = '0;
    repeat (3) step();
    rst = 1'b0;
    step();

    chk("rst done", 32'(alloc_done), 32'd0);
    chk("rst search_en", 32'(res_search_en), 32'd0);
    chk("rst wr_en", 32'(cam_wr_en), 32'd0);
    chk("rst ovf", 32'(dealloc_overflow), 32'd0);
    chk("rst aready", 32'(alloc_ready), 32'd1);
    chk("rst dready", 32'(dealloc_ready), 32'd1);

    do_alloc("t1", 11'd100, {64{1'b1}}, 1'b1, 1'b1, 6'd0, 11'd924);
    do_alloc("t2", 11'd50, 64'h0000_0000_0000_00F0, 1'b1, 1'b1, 6'd4, 11'd974);
    do_alloc("t3", 11'd200, 64'h0, 1'b1, 1'b0, 6'd0, 11'd0);
    do_alloc("t4", 11'd1025, {64{1'b1}}, 1'b0, 1'b0, 6'd0, 11'd0);
    do_dealloc("t5a", 6'd0, 11'd100, 11'd1024, 1'b0);
    do_dealloc("t5b", 6'd0, 11'd10, 11'd1024, 1'b1);

    // Simultaneous requests: dealloc cu4 (974+26=1000) wins, alloc 30 follows at N+2.
    res_search_out = 64'h10;
    dealloc_cu_id  = 6'd4;
    dealloc_size   = 11'd26;
    dealloc_valid  = 1'b1;
    alloc_size     = 11'd30;
    alloc_valid    = 1'b1;
    #1;
    chk("t6 aready blocked", 32'(alloc_ready), 32'd0);
    chk("t6 dready", 32'(dealloc_ready), 32'd1);
    step();
    dealloc_valid = 1'b0;
    chk("t6 n1 search_en", 32'(res_search_en), 32'd0);
    chk("t6 n1 aready", 32'(alloc_ready), 32'd0);
    step();
    chk("t6 n2 wr_en", 32'(cam_wr_en), 32'd1);
    chk("t6 n2 wr_addr", 32'(cam_wr_addr), 32'd4);
    chk("t6 n2 wr_data", 32'(cam_wr_data), 32'd1000);
    chk("t6 n2 ovf", 32'(dealloc_overflow), 32'd0);
    chk("t6 n2 aready", 32'(alloc_ready), 32'd1);
    step();
    alloc_valid = 1'b0;
    chk("t6 n3 search_en", 32'(res_search_en), 32'd1);
    chk("t6 n3 search_size", 32'(res_search_size), 32'd30);
    step();
    rst = 1'b1;
    #1;
    chk("t6 rst done", 32'(alloc_done), 32'd0);
    chk("t6 rst wr_en", 32'(cam_wr_en), 32'd0);
    chk("t6 rst search_en", 32'(res_search_en), 32'd0);
    chk("t6 rst aready", 32'(alloc_ready), 32'd1);
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t6 post-rst done", 32'(alloc_done), 32'd0);
      chk("t6 post-rst wr_en", 32'(cam_wr_en), 32'd0);
    end

    // Table for cu4 must be back at 1024; size 0 still issues the write.
    do_alloc("t7 size0", 11'd0, 64'h10, 1'b1, 1'b1, 6'd4, 11'd1024);
    do_alloc("t8 full", 11'd1024, {64{1'b1}}, 1'b1, 1'b1, 6'd0, 11'd0);
    do_alloc("t9 hi bit", 11'd1, 64'h8000_0000_0000_0000, 1'b1, 1'b1, 6'd63, 11'd1023);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
